// File: rtl/sd_line_bridge.sv
// Bridges 16-byte cache-line requests onto a 512-byte SD block engine.
// Writes are read-modify-write: the block is read into a local buffer, the line is patched in flight, then written back.
module sd_line_bridge #(
  parameter  int ADDR      = 32,
  parameter  int WIDTH     = 128,
  parameter  int CMD       = 1,
  parameter  int BLK_BYTES = 512,
  localparam int BLK_BITS  = $clog2(BLK_BYTES)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     line_valid_in,
  output logic                     line_ready_in,
  input  logic [ADDR-1:0]          line_addr_in,
  input  logic [WIDTH-1:0]         line_data_in,
  input  logic [CMD-1:0]           line_cmd_in,
  output logic                     line_valid_out,
  input  logic                     line_ready_out,
  output logic [WIDTH-1:0]         line_data_out,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [ADDR-BLK_BITS-1:0] blk_addr,
  output logic                     blk_cmd,
  input  logic                     rd_valid,
  output logic                     rd_ready,
  input  logic [7:0]               rd_data,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [7:0]               wr_data,
  input  logic                     blk_done,
  input  logic                     blk_err,
  output logic                     error
);
  localparam int LINE_BYTES = WIDTH / 8;
  localparam int LB_BITS    = $clog2(LINE_BYTES);
  localparam int OFF_BITS   = BLK_BITS - LB_BITS;
  localparam logic [BLK_BITS-1:0] CNT_ONE  = BLK_BITS'(1);
  localparam logic [BLK_BITS-1:0] CNT_LAST = BLK_BITS'(BLK_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BCMD, S_RSTREAM, S_RDONE, S_RESP, S_WCMD, S_WSTREAM, S_WDONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR-LB_BITS-1:0] laddr_q;
  logic [WIDTH-1:0]        wdata_q;
  logic                    is_write_q;
  logic [BLK_BITS-1:0]     cnt_q, cnt_d;
  logic                    error_q, error_d;
  logic [WIDTH-1:0]        line_q;
  logic [7:0]              blk_buf [BLK_BYTES];
  logic [7:0]              buf_rdata_q;
  logic [BLK_BITS-1:0]     buf_raddr;
  logic                    buf_we;
  logic [7:0]              buf_wdata;
  logic                    rd_fire, line_hit, line_we, line_clr;
  logic [LINE_BYTES-1:0]   line_byte_we;
  logic                    unused_addr_bits;

  // Byte-within-line address bits are irrelevant: whole lines only.
  assign unused_addr_bits = ^line_addr_in[LB_BITS-1:0];

  assign rd_fire       = rd_valid && rd_ready;
  assign line_hit      = cnt_q[BLK_BITS-1:LB_BITS] == laddr_q[OFF_BITS-1:0];
  assign blk_addr      = laddr_q[ADDR-LB_BITS-1:OFF_BITS];
  assign buf_we        = rd_fire && is_write_q;
  assign buf_wdata     = line_hit ? wdata_q[{cnt_q[LB_BITS-1:0], 3'b000} +: 8] : rd_data;
  assign line_we       = rd_fire && !is_write_q && line_hit;
  assign line_clr      = (state_q == S_RDONE) && blk_done && blk_err && !is_write_q;
  assign wr_data       = buf_rdata_q;
  assign line_data_out = line_q;
  assign error         = error_q;

  for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_line_we
    assign line_byte_we[gi] = line_we && (cnt_q[LB_BITS-1:0] == LB_BITS'(gi));
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    error_d        = error_q;
    line_ready_in  = 1'b0;
    line_valid_out = 1'b0;
    blk_valid      = 1'b0;
    blk_cmd        = 1'b0;
    rd_ready       = 1'b0;
    wr_valid       = 1'b0;
    buf_raddr      = cnt_q;
    case (state_q)
      S_IDLE: begin
        line_ready_in = !reset;
        if (line_valid_in && !reset) state_d = S_BCMD;
      end
      S_BCMD: begin
        blk_valid = 1'b1;
        if (blk_ready) state_d = S_RSTREAM;
      end
      S_RSTREAM: begin
        rd_ready = 1'b1;
        if (rd_valid) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_d = S_RDONE;
        end
      end
      S_RDONE: begin
        if (blk_done) begin
          if (blk_err) error_d = 1'b1;
          if (!is_write_q)  state_d = S_RESP;
          else if (blk_err) state_d = S_IDLE;
          else              state_d = S_WCMD;
        end
      end
      S_RESP: begin
        line_valid_out = 1'b1;
        if (line_ready_out) state_d = S_IDLE;
      end
      S_WCMD: begin
        blk_valid = 1'b1;
        blk_cmd   = 1'b1;
        if (blk_ready) state_d = S_WSTREAM;
      end
      S_WSTREAM: begin
        wr_valid = 1'b1;
        // Prefetch the next buffer byte so wr_data is ready the cycle after a transfer.
        if (wr_ready) begin
          cnt_d     = cnt_q + CNT_ONE;
          buf_raddr = cnt_d;
          if (cnt_q == CNT_LAST) state_d = S_WDONE;
        end
      end
      S_WDONE: begin
        if (blk_done) begin
          if (blk_err) error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clock) begin
    if (line_valid_in && line_ready_in) begin
      laddr_q    <= line_addr_in[ADDR-1:LB_BITS];
      wdata_q    <= line_data_in;
      is_write_q <= (line_cmd_in != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || line_clr) begin
      line_q <= '0;
    end else begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (line_byte_we[i]) line_q[8*i +: 8] <= rd_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (buf_we) blk_buf[cnt_q] <= buf_wdata;
    buf_rdata_q <= blk_buf[buf_raddr];
  end
endmodule
